mux_rr_arbiter: RTL

Round-robin arbiter that shares the four-input, one-output select mux between four requesters. It registers a one-hot grant and drives the mux select lines `s1`/`s0` so the granted requester's input reaches output `d`. It enforces a maximum hold time per grant so no requester can starve the others. It sits directly beside the 4:1 mux: its `s1`/`s0` outputs wire straight to the mux select inputs.

---
 rtl/mux_rr_arbiter_if.sv | 31 +++
 rtl/mux_rr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if
// Bundles the requester-side handshake and the mux select outputs of the
// round-robin arbiter.
//   req[3:0]  requests, req[k] belongs to requester k (level-sensitive)
//   done      current owner is finished (only looked at while a grant is active)
//   gnt[3:0]  one-hot grant, all zeros while idle
//   s1, s0    select lines for the 4:1 mux, {s1,s0} = owner index
//   valid     a grant is active (OR of gnt)
//   timeout   one-cycle pulse after a forced release at the hold limit
// Modports:
//   master  requester side: drives req/done, observes the arbiter outputs
//   slave   arbiter side: observes req/done, drives the arbiter outputs
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;
  logic       timeout;

  modport master (
    output req, done,
    input  gnt, s1, s0, valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, s1, s0, valid, timeout
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter for four requesters sharing a 4:1 select mux. A grant
// is registered as a one-hot vector plus the encoded mux select, and lasts
// until the owner signals done, drops its request, or has held the mux for
// MAX_HOLD cycles. Every release is followed by one idle cycle.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of mux_rr_arbiter_if (req/done in; gnt/s1/s0/valid/timeout out)
// Parameter:
//   MAX_HOLD  longest grant in cycles, 1..15
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  mux_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  // Requests rotated so that bit 0 is the highest-priority index (ptr).
  logic [3:0] req_rot;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rot
      logic [1:0] src_idx;
      assign src_idx     = ptr_q + 2'(gi);
      assign req_rot[gi] = bus.req[src_idx];
    end
  endgenerate

  // Offset of the first requester at or after ptr; the descending scan lets
  // the lowest offset win.
  logic [1:0] pick_off;
  always_comb begin
    pick_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_rot[i]) pick_off = 2'(i);
    end
  end

  logic [1:0] pick_idx;
  assign pick_idx = ptr_q + pick_off;

  logic rel_done, rel_drop, rel_hold;
  assign rel_done = bus.done;
  assign rel_drop = ~bus.req[owner_q];
  assign rel_hold = (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          owner_d = pick_idx;
          gnt_d   = 4'b0001 << pick_idx;
          sel_d   = pick_idx;
          valid_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          ptr_d     = owner_q + 2'd1;
          cnt_d     = 4'd0;
          state_d   = ST_IDLE;
          // Only a purely forced release is flagged; cooperative causes win.
          timeout_d = rel_hold && !rel_done && !rel_drop;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= 4'd0;
      owner_q   <= 2'd0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.s1      = sel_q[1];
  assign bus.s0      = sel_q[0];
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;

endmodule
